uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, LSB first, with one-cycle valid/frame_err strobes.
// Optional ASCII_DECODE_EN: the stored byte is the received byte minus 8'd48 ('0' -> 0).
module uart_rx #(
    parameter int BAUD = 115200,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV = F / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    os;
    logic [2:0]    bc;
    logic [7:0]    shreg;
    logic [7:0]    byte_out;

    // rx is asynchronous: two flops, reset to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], rx};
    end
    assign rxs = sync[1];

    // Tick counter is held at 0 in IDLE so the first tick of a frame lands DIV clk after the start edge
    assign tick = (state != IDLE) && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          cnt <= '0;
        else if (state == IDLE || tick)    cnt <= '0;
        else                               cnt <= cnt + 1'b1;
    end

`ifdef ASCII_DECODE_EN
    assign byte_out = shreg - 8'd48;
`else
    assign byte_out = shreg;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            os        <= '0;
            bc        <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        os    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os == 4'd7) begin
                            if (!rxs) begin
                                state <= DATA;
                                os    <= '0;
                                bc    <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            os <= os + 1'b1;
                        end
                    end
                end
                DATA: begin
                    // os wraps 15 -> 0, so each sample lands mid-bit 16 ticks after the previous one
                    if (tick) begin
                        os <= os + 1'b1;
                        if (os == 4'd15) begin
                            shreg <= {rxs, shreg[7:1]};
                            if (bc == 3'd7) state <= STOP;
                            else            bc    <= bc + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        os <= os + 1'b1;
                        if (os == 4'd15) begin
                            if (rxs) begin
                                data  <= byte_out;
                                valid <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes queued at send time, popped on each valid strobe.
module tb_uart_rx;
    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         vcnt = 0;
    int         ecnt = 0;
    logic       valid_d = 1'b0;
    logic       ferr_d = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] b);
`ifdef ASCII_DECODE_EN
        return b - 8'd48;
`else
        return b;
`endif
    endfunction

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(posedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            chk("valid_busy", {31'd0, busy}, 0);
            chk("valid_with_ferr", {31'd0, frame_err}, 0);
            chk("valid_width", {31'd0, valid_d}, 0);
            if (exp_q.size() == 0) chk("unexpected_valid", {31'd0, valid}, 0);
            else                   chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        if (frame_err) begin
            ecnt++;
            chk("ferr_width", {31'd0, ferr_d}, 0);
        end
        valid_d = valid;
        ferr_d  = frame_err;
    end

    initial begin
        int v0, e0, v1;
        logic [7:0] prev;

        // reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_ferr", {31'd0, frame_err}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b1;
        repeat (10) @(posedge clk);

        // single frame 0x55
        exp_q.push_back(model(8'h55));
        send(8'h55, 1'b1);
        drain("drain_55");
        repeat (5) @(posedge clk);
        #1;
        chk("valid_low_after", {31'd0, valid}, 0);
        chk("vcnt_55", vcnt, 1);

        // back-to-back 0x00, 0xFF with no idle gap
        exp_q.push_back(model(8'h00));
        exp_q.push_back(model(8'hFF));
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        drain("drain_b2b");
        chk("vcnt_b2b", vcnt, 3);
        chk("data_b2b", {24'd0, data}, {24'd0, model(8'hFF)});

        // 100-clk glitch low: rejected at mid start bit
        v0 = vcnt;
        e0 = ecnt;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        rx = 1'b1;
        for (int i = 0; i < 220 && busy; i++) @(posedge clk);
        #1;
        chk("glitch_busy", {31'd0, busy}, 0);
        repeat (500) @(posedge clk);
        chk("glitch_vcnt", vcnt, v0);
        chk("glitch_ecnt", ecnt, e0);

        // framing error, line held low, then a good frame
        prev = data;
        send(8'hA5, 1'b0);
        repeat (2000) @(posedge clk);
        #1;
        chk("ferr_count", ecnt, e0 + 1);
        chk("ferr_data_kept", {24'd0, data}, {24'd0, prev});
        chk("ferr_no_valid", vcnt, v0);
        chk("ferr_wait_busy", {31'd0, busy}, 1);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
        exp_q.push_back(model(8'h3C));
        send(8'h3C, 1'b1);
        drain("drain_after_ferr");
        chk("ferr_count_final", ecnt, e0 + 1);

        // reset during bit 4 of 0x81
        v1 = vcnt;
        fork
            send(8'h81, 1'b1);
            begin
                repeat (5 * BIT + 200) @(posedge clk);
                #1;
                chk("busy_mid_frame", {31'd0, busy}, 1);
                #2 rst = 1'b0;
                #1;
                chk("rst_mid_data", {24'd0, data}, 0);
                chk("rst_mid_valid", {31'd0, valid}, 0);
                chk("rst_mid_ferr", {31'd0, frame_err}, 0);
                chk("rst_mid_busy", {31'd0, busy}, 0);
            end
        join
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (BIT) @(posedge clk);
        chk("rst_no_strobe", vcnt, v1);
        exp_q.push_back(model(8'h3C));
        send(8'h3C, 1'b1);
        drain("drain_after_rst");

        // ASCII '7'
        exp_q.push_back(model(8'h37));
        send(8'h37, 1'b1);
        drain("drain_37");
        chk("ascii_data", {24'd0, data}, {24'd0, model(8'h37)});

        chk("queue_empty", exp_q.size(), 0);
        chk("valid_total", vcnt, 6);
        chk("ferr_total", ecnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
